// File: rtl/sevenseg_scan_decoder.sv
// Seven-segment scan decoder: samples the multiplexed CA/AN buses, waits for each
// digit slot to settle, then decodes it into an 8-digit hex/decimal-point frame image.
module sevenseg_scan_decoder #(
   parameter int unsigned SETTLE = 16,
   parameter int unsigned CNT_W  = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  CA,
   input  logic [7:0]  AN,
   output logic [31:0] DIGITS,
   output logic [7:0]  DP,
   output logic [7:0]  VALID_MASK,
   output logic [2:0]  POS,
   output logic        CAPTURE,
   output logic        FRAME,
   output logic        ERR
);

   localparam int unsigned NPOS   = 8;
   localparam int unsigned SNAP_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HOLD
   } state_t;

   state_t             state_r, state_n;
   logic [7:0]         ca_r, an_r;
   logic [SNAP_W-1:0]  snap_r, snap_n;
   logic [CNT_W-1:0]   cnt_r, cnt_n;
   logic [7:0]         seen_r;

   logic [7:0]         an_low_c;
   logic               onehot_c;
   logic               multi_c;
   logic               same_c;
   logic               cap_c;
   logic [2:0]         pos_c;
   logic [4:0]         glyph_c;
   logic [7:0]         seen_set_c;
   logic               frame_c;

   // Map a gfedcba segment pattern to {legal, nibble}; anything else is illegal.
   function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
      logic [4:0] res;
      case (seg)
         7'h3F:   res = {1'b1, 4'h0};
         7'h06:   res = {1'b1, 4'h1};
         7'h5B:   res = {1'b1, 4'h2};
         7'h4F:   res = {1'b1, 4'h3};
         7'h66:   res = {1'b1, 4'h4};
         7'h6D:   res = {1'b1, 4'h5};
         7'h7D:   res = {1'b1, 4'h6};
         7'h07:   res = {1'b1, 4'h7};
         7'h7F:   res = {1'b1, 4'h8};
         7'h6F:   res = {1'b1, 4'h9};
         7'h77:   res = {1'b1, 4'hA};
         7'h7C:   res = {1'b1, 4'hB};
         7'h39:   res = {1'b1, 4'hC};
         7'h5E:   res = {1'b1, 4'hD};
         7'h79:   res = {1'b1, 4'hE};
         7'h71:   res = {1'b1, 4'hF};
         default: res = {1'b0, 4'h0};
      endcase
      return res;
   endfunction

   // Anode classification on the registered bus.
   always_comb begin
      an_low_c = ~an_r;
      onehot_c = (an_low_c != 8'h00) && ((an_low_c & (an_low_c - 8'd1)) == 8'h00);
      multi_c  = (an_low_c != 8'h00) && !onehot_c;
      same_c   = ({an_r, ca_r} == snap_r);
   end

   // Next-state logic: track one stable slot and capture it exactly once.
   always_comb begin
      state_n = state_r;
      snap_n  = snap_r;
      cnt_n   = cnt_r;
      cap_c   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (onehot_c) begin
               snap_n  = {an_r, ca_r};
               cnt_n   = CNT_W'(1);
               state_n = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!same_c) begin
               if (onehot_c) begin
                  snap_n = {an_r, ca_r};
                  cnt_n  = CNT_W'(1);
               end else begin
                  state_n = ST_IDLE;
               end
            end else if (cnt_r == CNT_W'(SETTLE)) begin
               cap_c   = 1'b1;
               state_n = ST_HOLD;
            end else begin
               cnt_n = cnt_r + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (!same_c) begin
               if (onehot_c) begin
                  snap_n  = {an_r, ca_r};
                  cnt_n   = CNT_W'(1);
                  state_n = ST_SETTLE;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Decode the settled slot held in the snapshot.
   always_comb begin
      pos_c = 3'd0;
      for (int unsigned i = 0; i < NPOS; i++) begin
         if (!snap_r[8 + i]) pos_c = 3'(i);
      end
      glyph_c    = decode_glyph(~snap_r[6:0]);
      seen_set_c = seen_r | (8'd1 << pos_c);
      frame_c    = cap_c && (seen_set_c == 8'hFF);
   end

   // Input stage: all decisions use registered CA/AN.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ca_r <= 8'hFF;
         an_r <= 8'hFF;
      end else begin
         ca_r <= CA;
         an_r <= AN;
      end
   end

   // FSM state, snapshot and settle counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_IDLE;
         snap_r  <= '0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_n;
         snap_r  <= snap_n;
         cnt_r   <= cnt_n;
      end
   end

   // Frame image, pulses, sticky error and seen-mask.
   always_ff @(posedge CLK) begin
      if (RST) begin
         DIGITS     <= '0;
         DP         <= '0;
         VALID_MASK <= '0;
         POS        <= '0;
         CAPTURE    <= 1'b0;
         FRAME      <= 1'b0;
         ERR        <= 1'b0;
         seen_r     <= '0;
      end else begin
         CAPTURE <= cap_c;
         FRAME   <= frame_c;
         if (multi_c) ERR <= 1'b1;
         if (cap_c) begin
            POS                          <= pos_c;
            DP[pos_c]                    <= ~snap_r[7];
            DIGITS[{pos_c, 2'b00} +: 4]  <= glyph_c[3:0];
            VALID_MASK[pos_c]            <= glyph_c[4];
            seen_r                       <= frame_c ? 8'h00 : seen_set_c;
         end
      end
   end

endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
- Receiving end of the multiplexed seven-segment display interface driven by the board top level (CA/AN).
- Samples the active-low segment bus and active-low one-hot anode bus, and waits for each digit slot to settle.
- Decodes each settled slot back to a hex nibble plus decimal point and holds an 8-digit frame image.
- Used as a self-checking monitor in benches and as a loopback checker on hardware.

Parameters:
- SETTLE, 16, cycles CA/AN must be unchanged before a slot is captured (must be >= 1)
- CNT_W, 8, width of the settle counter (must hold SETTLE)

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  synchronous, active-high reset
- CA  input  8  segment bus, active-low; CA[0]=a … CA[6]=g, CA[7]=dp
- AN  input  8  anode bus, active-low, one-hot-low selects digit position 0..7
- DIGITS  output  32  decoded nibbles; DIGITS[4p+3:4p] = position p
- DP  output  8  decimal point per position, active-high
- VALID_MASK  output  8  bit p set = last capture at p decoded to a legal hex glyph
- POS  output  3  position of most recent capture
- CAPTURE  output  1  one-cycle pulse per captured slot
- FRAME  output  1  one-cycle pulse when all 8 positions captured since last FRAME
- ERR  output  1  sticky; set when AN has two or more bits low

Behaviour:
- Reset values:
  - DIGITS=0, DP=0, VALID_MASK=0, POS=0, CAPTURE=0, FRAME=0, ERR=0.
  - Internal seen-mask=0, counter=0, state=IDLE.
- Input stage: CA and AN registered once (ca_r, an_r). All decisions use the registered values.
- AN classification on an_r:
  - BLANK: 8'hFF.
  - ONEHOT: exactly one bit 0.
  - MULTI: two or more bits 0. MULTI sets ERR the cycle after it appears in an_r. ERR clears only on RST.
- States:
  - IDLE: if ONEHOT, snapshot {an_r, ca_r}, counter=1, go SETTLE. Otherwise stay.
  - SETTLE:
    - If {an_r, ca_r} ≠ snapshot: if ONEHOT, re-snapshot and counter=1, stay; else go IDLE.
    - Else if counter == SETTLE: capture and go HOLD. Otherwise counter+1.
  - HOLD: stay while {an_r, ca_r} == snapshot, so one slot is never captured twice. On any change, evaluate exactly as IDLE in the same cycle.
- Capture (registered, visible the cycle after the decision):
  - p = index of the low AN bit; POS=p; CAPTURE=1 for one cycle.
  - DP[p] = ~CA[7].
  - Segment pattern s = ~CA[6:0] (gfedcba). Legal glyphs:
    - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
    - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Match: nibble written to DIGITS[p], VALID_MASK[p]=1.
  - No match (including blank 00): DIGITS[p]=0, VALID_MASK[p]=0.
  - Other positions unchanged.
- Frame:
  - seen-mask |= (1<<p) on capture.
  - If the result is 8'hFF: FRAME=1 in the same cycle as CAPTURE, and seen-mask clears to 0.
  - A repeat capture of an already-seen position overwrites its data and does not pulse FRAME.
- Latency: pins stable from sampling edge k → an_r valid at k+1 → CAPTURE high at edge k+SETTLE+1.
- Ordering is not assumed; positions may arrive in any order.
- RST mid-SETTLE or mid-HOLD: everything returns to reset values next cycle. A slot pending before reset must settle again from scratch.

Test Plan:
- Reset check: RST=1 for 2 cycles with AN=8'h00 (MULTI) → all outputs 0 during and after reset, ERR=0 until one cycle after release.
- Single digit: SETTLE=16, AN=8'hFE, CA=8'hC0 held 20 cycles → one CAPTURE at k+17, POS=0, DIGITS[3:0]=0, VALID_MASK=8'h01, DP[0]=0, FRAME=0, no second CAPTURE.
- Full frame: scan positions 0..7 with glyphs 1,2,3,4,5,6,7,8, each held 20 cycles, dp on position 3 (CA[7]=0) → DIGITS=32'h87654321, DP=8'h08, VALID_MASK=8'hFF, FRAME pulses exactly once, with capture of position 7.
- Glitch rejection: AN=8'hFD, CA changes glyph after 10 cycles then holds 20 → only the second glyph captured, CAPTURE count 1.
- Illegal and blank handling:
  - CA=8'hFF on position 5 → VALID_MASK[5]=0, DIGITS[23:20]=0.
  - Then AN=8'hFC for 1 cycle → ERR=1 and stays 1 through further legal scans.
  - AN=8'hFF for 100 cycles → no CAPTURE, ERR unchanged.
- Reset mid-settle: AN=8'hBF held, RST pulsed at cycle 8 → no CAPTURE until 17 cycles after RST deasserts. Seen-mask restarts, so 8 new positions are needed for FRAME.
